// File: rtl/ref_line_buf_if.sv
// ref_line_buf_if: input beat handshake and window-row output of the reference-line buffer
interface ref_line_buf_if #(
  parameter int IN_W = 64,
  parameter int OUT_W = 184
);
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in_data;
  logic out_valid;
  logic [OUT_W-1:0] out_data;
  modport master(output in_valid, in_data, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, output in_ready, out_valid, out_data);
endinterface

// File: rtl/ref_line_buf.sv
// ref_line_buf: rotating reference-line buffer, one bank filled while the others form a search-window row
module ref_line_buf #(
  parameter int PIX_W = 8,
  parameter int WORD_PIX = 8,
  parameter int DEPTH = 23,
  parameter int NUM_BANKS = 4,
  parameter int OUT_PIX = 23,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  input logic next_line,
  ref_line_buf_if.slave bus,
  output logic warm,
  output logic [NUM_BANKS-1:0] wr_bank,
  output logic [AW-1:0] addr
);
  localparam int WW = WORD_PIX * PIX_W;
  localparam int CW = (NUM_BANKS - 1) * WW;
  localparam int OW = OUT_PIX * PIX_W;
  localparam int IW = $clog2(NUM_BANKS);
  logic acc;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] sel_q;
  logic vld_q;
  logic [NUM_BANKS-1:0][WW-1:0] qa;
  logic [CW-1:0] cat;
  assign bus.in_ready = !next_line;
  assign acc = bus.in_valid && bus.in_ready && !rst;
  assign wr_bank = NUM_BANKS'(1) << wr_idx;
  assign bus.out_valid = vld_q;
  assign bus.out_data = cat[CW-1 -: OW];
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WW-1:0] mem [DEPTH];
    logic [WW-1:0] q;
    always_ff @(posedge clk)
      if (acc) begin
        if (wr_idx == IW'(b)) mem[addr] <= bus.in_data;
        else q <= mem[addr];
      end
    assign qa[b] = q;
  end
  always_ff @(posedge clk) begin
    if (rst || next_line) begin
      addr <= '0;
      wr_idx <= '0;
      warm <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= acc && warm;
      if (acc) begin
        // sel_q records the bank written now, since wr_idx may advance on this beat
        sel_q <= wr_idx;
        if (addr == AW'(DEPTH - 1)) begin
          addr <= '0;
          wr_idx <= (wr_idx == IW'(NUM_BANKS - 1)) ? '0 : wr_idx + 1'b1;
          if (wr_idx == IW'(NUM_BANKS - 2)) warm <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end
    end
  end
  // Oldest bank (the one after the bank being written) lands in the MSBs
  always_comb begin
    cat = '0;
    for (int j = 1; j < NUM_BANKS; j++)
      cat[(NUM_BANKS-1-j)*WW +: WW] = qa[IW'((int'(sel_q) + j) % NUM_BANKS)];
  end
endmodule
